instr_decode_ctrl: RTL

INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

---
 rtl/cpu_pkg.sv | 139 +++++++++++++
 rtl/imm_extend.sv | 35 +++
 rtl/instr_decode_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/state enums and MIPS-I field encodings
package cpu_pkg;

  // ALU opcode; 0 means no operation is being presented to the ALU.
  typedef enum logic [6:0] {
    OP_NOP    = 7'd0,
    OP_ADD    = 7'd1,
    OP_ADDI   = 7'd2,
    OP_ADDIU  = 7'd3,
    OP_ADDU   = 7'd4,
    OP_SUB    = 7'd5,
    OP_SUBU   = 7'd6,
    OP_SLT    = 7'd7,
    OP_SLTI   = 7'd8,
    OP_SLTIU  = 7'd9,
    OP_SLTU   = 7'd10,
    OP_AND    = 7'd11,
    OP_ANDI   = 7'd12,
    OP_LUI    = 7'd13,
    OP_NOR    = 7'd14,
    OP_OR     = 7'd15,
    OP_ORI    = 7'd16,
    OP_XOR    = 7'd17,
    OP_XORI   = 7'd18,
    OP_SLL    = 7'd19,
    OP_SLLV   = 7'd20,
    OP_SRL    = 7'd21,
    OP_SRLV   = 7'd22,
    OP_SRA    = 7'd23,
    OP_SRAV   = 7'd24,
    OP_MULT   = 7'd25,
    OP_MULTU  = 7'd26,
    OP_DIV    = 7'd27,
    OP_DIVU   = 7'd28,
    OP_MFHI   = 7'd29,
    OP_MFLO   = 7'd30,
    OP_BEQ    = 7'd31,
    OP_BNE    = 7'd32,
    OP_BLEZ   = 7'd33,
    OP_BGTZ   = 7'd34,
    OP_BLTZ   = 7'd35,
    OP_BGEZ   = 7'd36,
    OP_BLTZAL = 7'd37,
    OP_BGEZAL = 7'd38,
    OP_J      = 7'd39,
    OP_JAL    = 7'd40,
    OP_JR     = 7'd41,
    OP_JALR   = 7'd42,
    OP_LB     = 7'd43,
    OP_LBU    = 7'd44,
    OP_LH     = 7'd45,
    OP_LHU    = 7'd46,
    OP_LW     = 7'd47,
    OP_LWL    = 7'd48,
    OP_LWR    = 7'd49,
    OP_SB     = 7'd50,
    OP_SH     = 7'd51,
    OP_SW     = 7'd52
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC1  = 2'd1,
    ST_EXEC2  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Primary opcode field IR[31:26].
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_REGIMM  = 6'h01;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LH      = 6'h21;
  localparam logic [5:0] OPC_LWL     = 6'h22;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] OPC_LHU     = 6'h25;
  localparam logic [5:0] OPC_LWR     = 6'h26;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SH      = 6'h29;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct field IR[5:0].
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM rt field IR[20:16].
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BLTZAL = 5'd16;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

  // Loads and multiply/divide need a second execute cycle for memory or the
  // iterative unit, so the FSM routes them through EXEC2.
  function automatic logic needs_exec2(input op_e op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - immediate extension selected by decoded opcode
module imm_extend
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  input  op_e         op,
  output logic [31:0] imm_ext
);

  // Opcode field is not needed here; op already carries the decode.
  logic unused_opcode;
  assign unused_opcode = ^ir[31:26];

  // Pick the extension form that matches how the ALU consumes the operand.
  always_comb begin
    imm_ext = 32'h0;
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SW,
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL:
        imm_ext = {{16{ir[15]}}, ir[15:0]};
      OP_ANDI, OP_ORI, OP_XORI:
        imm_ext = {16'h0, ir[15:0]};
      OP_LUI:
        imm_ext = {ir[15:0], 16'h0};
      OP_J, OP_JAL:
        imm_ext = {4'h0, ir[25:0], 2'b00};
      default:
        imm_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// rtl/instr_decode_ctrl.sv - fetch/execute FSM and MIPS-I decode; DECODE_ILLEGAL_HALT_EN halts on illegal
module instr_decode_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_readdata,
  input  logic        waitrequest,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [6:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  sa,
  output logic [31:0] imm_ext,
  output logic        illegal,
  output logic        active
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  op_e         dec_op;
  logic        dec_illegal;

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign sa     = {1'b0, ir_q[10:6]};

  // State and instruction register; reset forces FETCH and a zero IR at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Instruction decode of the IR into the ALU opcode plus an illegal flag.
  always_comb begin
    dec_op      = OP_NOP;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_SPECIAL: begin
        case (funct)
          FN_SLL:   dec_op = OP_SLL;
          FN_SRL:   dec_op = OP_SRL;
          FN_SRA:   dec_op = OP_SRA;
          FN_SLLV:  dec_op = OP_SLLV;
          FN_SRLV:  dec_op = OP_SRLV;
          FN_SRAV:  dec_op = OP_SRAV;
          FN_JR:    dec_op = OP_JR;
          FN_JALR:  dec_op = OP_JALR;
          FN_MFHI:  dec_op = OP_MFHI;
          FN_MFLO:  dec_op = OP_MFLO;
          FN_MULT:  dec_op = OP_MULT;
          FN_MULTU: dec_op = OP_MULTU;
          FN_DIV:   dec_op = OP_DIV;
          FN_DIVU:  dec_op = OP_DIVU;
          FN_ADD:   dec_op = OP_ADD;
          FN_ADDU:  dec_op = OP_ADDU;
          FN_SUB:   dec_op = OP_SUB;
          FN_SUBU:  dec_op = OP_SUBU;
          FN_AND:   dec_op = OP_AND;
          FN_OR:    dec_op = OP_OR;
          FN_XOR:   dec_op = OP_XOR;
          FN_NOR:   dec_op = OP_NOR;
          FN_SLT:   dec_op = OP_SLT;
          FN_SLTU:  dec_op = OP_SLTU;
          default:  dec_illegal = 1'b1;
        endcase
      end
      OPC_REGIMM: begin
        case (rt)
          RT_BLTZ:   dec_op = OP_BLTZ;
          RT_BGEZ:   dec_op = OP_BGEZ;
          RT_BLTZAL: dec_op = OP_BLTZAL;
          RT_BGEZAL: dec_op = OP_BGEZAL;
          default:   dec_illegal = 1'b1;
        endcase
      end
      OPC_J:     dec_op = OP_J;
      OPC_JAL:   dec_op = OP_JAL;
      OPC_BEQ:   dec_op = OP_BEQ;
      OPC_BNE:   dec_op = OP_BNE;
      OPC_BLEZ:  dec_op = OP_BLEZ;
      OPC_BGTZ:  dec_op = OP_BGTZ;
      OPC_ADDI:  dec_op = OP_ADDI;
      OPC_ADDIU: dec_op = OP_ADDIU;
      OPC_SLTI:  dec_op = OP_SLTI;
      OPC_SLTIU: dec_op = OP_SLTIU;
      OPC_ANDI:  dec_op = OP_ANDI;
      OPC_ORI:   dec_op = OP_ORI;
      OPC_XORI:  dec_op = OP_XORI;
      OPC_LUI:   dec_op = OP_LUI;
      OPC_LB:    dec_op = OP_LB;
      OPC_LH:    dec_op = OP_LH;
      OPC_LWL:   dec_op = OP_LWL;
      OPC_LW:    dec_op = OP_LW;
      OPC_LBU:   dec_op = OP_LBU;
      OPC_LHU:   dec_op = OP_LHU;
      OPC_LWR:   dec_op = OP_LWR;
      OPC_SB:    dec_op = OP_SB;
      OPC_SH:    dec_op = OP_SH;
      OPC_SW:    dec_op = OP_SW;
      default:   dec_illegal = 1'b1;
    endcase
  end

  // Next state, IR load and one-hot strobes from the current state.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    fetch   = 1'b0;
    exec1   = 1'b0;
    exec2   = 1'b0;
    active  = 1'b1;
    case (state_q)
      ST_FETCH: begin
        fetch = 1'b1;
        if (!waitrequest) begin
          ir_d    = instr_readdata;
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        exec1 = 1'b1;
        if (needs_exec2(dec_op)) begin
          state_d = ST_EXEC2;
        end else begin
          state_d = ST_FETCH;
        end
`ifdef DECODE_ILLEGAL_HALT_EN
        if (dec_illegal) begin
          state_d = ST_HALTED;
        end
`endif
      end
      ST_EXEC2: begin
        exec2 = 1'b1;
        if (!waitrequest) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
`ifdef DECODE_ILLEGAL_HALT_EN
        active = 1'b0;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Decoded opcode is only presented to the ALU while executing.
  assign op      = (exec1 || exec2) ? dec_op : OP_NOP;
  assign illegal = exec1 && dec_illegal;

  imm_extend u_imm_extend (
    .ir      (ir_q),
    .op      (dec_op),
    .imm_ext (imm_ext)
  );

endmodule
